// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard / sequencing controller for a 5-stage pipeline. It decides,
// every cycle, which pipeline registers advance, where NOPs are injected, where
// the PC comes from, and which EX operands are forwarded.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   id_valid, id_rs1/2, id_use_rs1/2 ID-stage source operands
//   ex_rs1/2, ex_rd, ex_regwrite,
//   ex_load, ex_redirect             EX-stage operands, destination, load flag,
//                                    resolved taken branch / jump
//   mem_rd/mem_regwrite,
//   wb_rd/wb_regwrite                MEM / WB destinations (forwarding sources)
//   dmem_busy                        data memory not ready (freezes pipeline)
//   pc_en, ifid_en, idex_en,
//   exmem_en                         pipeline-register enables
//   pc_sel                           1 = take the redirect target
//   ifid_flush, idex_bubble,
//   memwb_bubble                     NOP injection
//   fwd_a, fwd_b                     00 regfile, 01 from MEM, 10 from WB
//   state                            0 RUN, 1 MEM_WAIT, 2 FLUSH
//   stall_cycles, flush_events       saturating performance counters
//
// All control outputs are combinational from the registered state and the
// current inputs. While rst_n is low they are forced to their safe values
// immediately, without waiting for a clock edge.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_load,
  input  logic                  ex_redirect,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_regwrite,
  input  logic                  wb_regwrite,
  input  logic                  dmem_busy,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  pc_sel,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  memwb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  // Flush count is 3 bits wide: FLUSH_CYCLES is limited to 0..7.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_flush_cnt;
  logic [2:0]      w_flush_cnt_next;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;
  logic            w_redirect_acc;
  logic            w_load_use;

  // -------------------------------------------------------------------------
  // Forwarding: one identical selector per EX operand. MEM is the younger
  // producer so it wins over WB; x0 is hard-wired zero and never forwarded.
  // -------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] w_ex_rs [2];
  logic [1:0]            w_fwd   [2];

  assign w_ex_rs[0] = ex_rs1;
  assign w_ex_rs[1] = ex_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic w_hit_mem;
      logic w_hit_wb;
      assign w_hit_mem = mem_regwrite && (mem_rd != '0) && (mem_rd == w_ex_rs[gi]);
      assign w_hit_wb  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == w_ex_rs[gi]);
      assign w_fwd[gi] = w_hit_mem ? 2'b01 : (w_hit_wb ? 2'b10 : 2'b00);
    end
  endgenerate

  assign fwd_a = rst_n ? w_fwd[0] : 2'b00;
  assign fwd_b = rst_n ? w_fwd[1] : 2'b00;

  // A load in EX whose result the ID instruction needs cannot be forwarded in
  // time; ID must wait one cycle until the load reaches MEM.
  assign w_load_use = ex_load && ex_regwrite && (ex_rd != '0) && id_valid &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

  // -------------------------------------------------------------------------
  // Next-state and control decode. Priority: memory freeze, then redirect,
  // then load-use stall.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_redirect_acc   = 1'b0;
    pc_en            = 1'b1;
    ifid_en          = 1'b1;
    idex_en          = 1'b1;
    exmem_en         = 1'b1;
    pc_sel           = 1'b0;
    ifid_flush       = 1'b0;
    idex_bubble      = 1'b0;
    memwb_bubble     = 1'b0;

    if (dmem_busy) begin
      // Whole pipeline holds; only WB drains. A redirect in EX stays put and
      // is taken once memory is ready again. The flush count is preserved.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      w_state_next = ST_MEM_WAIT;
    end else if (r_state == ST_FLUSH) begin
      // IMEM is still returning wrong-path words; keep discarding them.
      // EX holds a bubble here, so redirect and load-use are meaningless.
      ifid_flush       = 1'b1;
      idex_bubble      = 1'b1;
      w_flush_cnt_next = (r_flush_cnt == 3'd0) ? 3'd0 : r_flush_cnt - 3'd1;
      w_state_next     = (r_flush_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
    end else if (ex_redirect) begin
      // RUN or MEM_WAIT: a redirect restarts the flush window from scratch.
      pc_sel         = 1'b1;
      ifid_flush     = 1'b1;
      idex_bubble    = 1'b1;
      w_redirect_acc = 1'b1;
      if (FLUSH_CYCLES != 0) begin
        w_state_next     = ST_FLUSH;
        w_flush_cnt_next = FLUSH_LOAD;
      end else begin
        w_state_next     = ST_RUN;
        w_flush_cnt_next = 3'd0;
      end
    end else begin
      if (w_load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
      // Leaving a freeze that interrupted a flush resumes the remaining flush.
      if ((r_state == ST_MEM_WAIT) && (r_flush_cnt != 3'd0)) begin
        w_state_next = ST_FLUSH;
      end else begin
        w_state_next = ST_RUN;
      end
    end

    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      pc_sel       = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State and counters.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_flush_cnt    <= 3'd0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_redirect_acc && (r_flush_events != {CNT_W{1'b1}})) begin
        r_flush_events <= r_flush_events + 1'b1;
      end
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_regwrite, ex_load, ex_redirect, mem_regwrite, wb_regwrite, dmem_busy;

  logic       a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_pc_sel;
  logic       a_ifid_flush, a_idex_bubble, a_memwb_bubble;
  logic [1:0] a_fwd_a, a_fwd_b, a_state;
  logic [15:0] a_stall, a_fev;

  logic       b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_pc_sel;
  logic       b_ifid_flush, b_idex_bubble, b_memwb_bubble;
  logic [1:0] b_fwd_a, b_fwd_b, b_state;
  logic [3:0] b_stall, b_fev;

  pipeline_hazard_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_load(ex_load), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .dmem_busy(dmem_busy), .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en),
    .exmem_en(a_exmem_en), .pc_sel(a_pc_sel), .ifid_flush(a_ifid_flush),
    .idex_bubble(a_idex_bubble), .memwb_bubble(a_memwb_bubble), .fwd_a(a_fwd_a),
    .fwd_b(a_fwd_b), .state(a_state), .stall_cycles(a_stall), .flush_events(a_fev)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_load(ex_load), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .dmem_busy(dmem_busy), .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
    .exmem_en(b_exmem_en), .pc_sel(b_pc_sel), .ifid_flush(b_ifid_flush),
    .idex_bubble(b_idex_bubble), .memwb_bubble(b_memwb_bubble), .fwd_a(b_fwd_a),
    .fwd_b(b_fwd_b), .state(b_state), .stall_cycles(b_stall), .flush_events(b_fev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc_en, ifid_en, idex_en, exmem_en, pc_sel;
    int ifid_flush, idex_bubble, memwb_bubble;
    int fa, fb, st, stall, fev;
  } obs_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: mode 0 RUN, 1 waiting on memory, 2 flushing.
  int FC   [2] = '{1, 2};
  int CMAX [2] = '{65535, 15};
  int m_st [2], m_cnt [2], m_stall [2], m_fev [2];
  int n_st [2], n_cnt [2], n_stall [2], n_fev [2];

  function automatic int fwd_of(logic [4:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 1;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  function automatic obs_t model_eval(int k);
    obs_t e;
    bit   lu;
    bit   acc;
    e = '{default: 0};
    e.st = m_st[k]; e.stall = m_stall[k]; e.fev = m_fev[k];
    if (!rst_n) begin
      e.ifid_flush = 1; e.idex_bubble = 1; e.memwb_bubble = 1;
      n_st[k] = 0; n_cnt[k] = 0; n_stall[k] = 0; n_fev[k] = 0;
      return e;
    end
    e.fa = fwd_of(ex_rs1);
    e.fb = fwd_of(ex_rs2);
    lu = ex_load && ex_regwrite && ex_rd != 0 && id_valid &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    acc = 0;
    n_st[k] = m_st[k]; n_cnt[k] = m_cnt[k];
    if (dmem_busy) begin
      e.memwb_bubble = 1;
      n_st[k] = 1;
    end else begin
      e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1;
      if (m_st[k] == 2) begin
        e.ifid_flush = 1; e.idex_bubble = 1;
        n_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
        n_st[k]  = (n_cnt[k] == 0) ? 0 : 2;
      end else if (ex_redirect) begin
        e.pc_sel = 1; e.ifid_flush = 1; e.idex_bubble = 1;
        acc = 1;
        n_cnt[k] = FC[k];
        n_st[k]  = (FC[k] > 0) ? 2 : 0;
      end else begin
        if (lu) begin
          e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 1;
        end
        n_st[k] = (m_st[k] == 1 && m_cnt[k] != 0) ? 2 : 0;
      end
    end
    n_stall[k] = (e.pc_en == 0 && m_stall[k] < CMAX[k]) ? m_stall[k] + 1 : m_stall[k];
    n_fev[k]   = (acc && m_fev[k] < CMAX[k]) ? m_fev[k] + 1 : m_fev[k];
    return e;
  endfunction

  function automatic obs_t get_obs(int k);
    obs_t o;
    if (k == 0) begin
      o = '{int'(a_pc_en), int'(a_ifid_en), int'(a_idex_en), int'(a_exmem_en), int'(a_pc_sel),
            int'(a_ifid_flush), int'(a_idex_bubble), int'(a_memwb_bubble),
            int'(a_fwd_a), int'(a_fwd_b), int'(a_state), int'(a_stall), int'(a_fev)};
    end else begin
      o = '{int'(b_pc_en), int'(b_ifid_en), int'(b_idex_en), int'(b_exmem_en), int'(b_pc_sel),
            int'(b_ifid_flush), int'(b_idex_bubble), int'(b_memwb_bubble),
            int'(b_fwd_a), int'(b_fwd_b), int'(b_state), int'(b_stall), int'(b_fev)};
    end
    return o;
  endfunction

  task automatic chk(int k, string nm, int act, int ex);
    n_checks++;
    if (act != ex) begin
      n_err++;
      $display("FAIL cyc=%0d inst%0d %s got=%0d exp=%0d", cyc, k, nm, act, ex);
    end
  endtask

  task automatic lit(string nm, int act, int ex);
    chk(0, nm, act, ex);
  endtask

  // Advance one clock: commit the model's next state at the edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_st[k] = n_st[k]; m_cnt[k] = n_cnt[k]; m_stall[k] = n_stall[k]; m_fev[k] = n_fev[k];
    end
    cyc++;
    #1;
  endtask

  // Compare both DUTs against the model for the current inputs.
  task automatic evalchk();
    obs_t e;
    obs_t a;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_st[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_fev[k] = 0;
      end
      e = model_eval(k);
      a = get_obs(k);
      chk(k, "pc_en", a.pc_en, e.pc_en);
      chk(k, "ifid_en", a.ifid_en, e.ifid_en);
      chk(k, "idex_en", a.idex_en, e.idex_en);
      chk(k, "exmem_en", a.exmem_en, e.exmem_en);
      chk(k, "pc_sel", a.pc_sel, e.pc_sel);
      chk(k, "ifid_flush", a.ifid_flush, e.ifid_flush);
      chk(k, "idex_bubble", a.idex_bubble, e.idex_bubble);
      chk(k, "memwb_bubble", a.memwb_bubble, e.memwb_bubble);
      chk(k, "fwd_a", a.fa, e.fa);
      chk(k, "fwd_b", a.fb, e.fb);
      chk(k, "state", a.st, e.st);
      chk(k, "stall_cycles", a.stall, e.stall);
      chk(k, "flush_events", a.fev, e.fev);
    end
    $display("cyc=%0d rst_n=%0b busy=%0b redir=%0b pc_en=%0b state=%0d stall=%0d fev=%0d",
             cyc, rst_n, dmem_busy, ex_redirect, a_pc_en, a_state, a_stall, a_fev);
  endtask

  task automatic quiet();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_load = 0; ex_redirect = 0;
    mem_rd = 0; wb_rd = 0; mem_regwrite = 0; wb_regwrite = 0; dmem_busy = 0;
  endtask

  task automatic set_lu(logic [4:0] rd);
    ex_load = 1; ex_regwrite = 1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1; id_valid = 1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_fev[k] = 0;
      n_st[k] = 0; n_cnt[k] = 0; n_stall[k] = 0; n_fev[k] = 0;
    end
    rst_n = 0;
    quiet();
    #2;
    evalchk();
    lit("rst_pc_en", int'(a_pc_en), 0);
    lit("rst_memwb_bubble", int'(b_memwb_bubble), 1);

    tick(); rst_n = 1; evalchk();
    lit("run_pc_en", int'(a_pc_en), 1);
    lit("run_ifid_en", int'(a_ifid_en), 1);

    // Load-use: one stall cycle.
    tick(); set_lu(5'd5); evalchk();
    lit("lu_pc_en", int'(a_pc_en), 0);
    lit("lu_idex_bubble", int'(a_idex_bubble), 1);
    tick(); quiet(); evalchk();
    lit("lu_stall_cycles", int'(a_stall), 1);
    lit("lu_done_pc_en", int'(a_pc_en), 1);
    tick(); set_lu(5'd0); evalchk();
    lit("lu_x0_pc_en", int'(a_pc_en), 1);

    // Forwarding priority.
    tick(); quiet(); ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1; evalchk();
    lit("fwd_mem", int'(a_fwd_a), 1);
    tick(); mem_regwrite = 0; evalchk();
    lit("fwd_wb", int'(a_fwd_a), 2);
    tick(); wb_rd = 0; evalchk();
    lit("fwd_x0", int'(a_fwd_a), 0);

    // Redirect pulse.
    tick(); quiet(); ex_redirect = 1; evalchk();
    lit("redir_pc_sel", int'(a_pc_sel), 1);
    lit("redir_state", int'(a_state), 0);
    tick(); ex_redirect = 0; evalchk();
    lit("flush_state", int'(a_state), 2);
    lit("flush_pc_sel", int'(a_pc_sel), 0);
    lit("flush_ifid_flush", int'(a_ifid_flush), 1);
    lit("flush_events", int'(a_fev), 1);
    tick(); evalchk();
    lit("after_flush_state", int'(a_state), 0);
    lit("after_flush_ifid_flush", int'(a_ifid_flush), 0);
    tick(); evalchk();

    // Freeze with redirect and load-use pending.
    for (int i = 0; i < 3; i++) begin
      tick(); quiet(); dmem_busy = 1; ex_redirect = 1; set_lu(5'd3); evalchk();
      lit("frz_memwb_bubble", int'(a_memwb_bubble), 1);
      lit("frz_pc_en", int'(a_pc_en), 0);
      if (i > 0) lit("frz_state", int'(a_state), 1);
    end
    tick(); dmem_busy = 0; evalchk();
    lit("unfrz_state", int'(a_state), 1);
    lit("unfrz_pc_sel", int'(a_pc_sel), 1);
    lit("unfrz_pc_en", int'(a_pc_en), 1);
    lit("unfrz_stall", int'(a_stall), 4);
    tick(); quiet(); evalchk();
    lit("unfrz_flush_state", int'(a_state), 2);
    lit("unfrz_fev", int'(a_fev), 2);
    for (int i = 0; i < 3; i++) begin tick(); evalchk(); end

    // Long freeze: 4-bit counter saturates.
    for (int i = 0; i < 20; i++) begin tick(); quiet(); dmem_busy = 1; evalchk(); end
    tick(); dmem_busy = 0; evalchk();
    lit("sat_stall_b", int'(b_stall), 15);
    lit("sat_stall_a", int'(a_stall), 24);

    // Async reset in the middle of a flush.
    tick(); quiet(); ex_redirect = 1; evalchk();
    tick(); ex_redirect = 0; evalchk();
    lit("pre_rst_state", int'(a_state), 2);
    #2 rst_n = 0;
    evalchk();
    lit("arst_pc_en", int'(a_pc_en), 0);
    lit("arst_ifid_flush", int'(a_ifid_flush), 1);
    lit("arst_state", int'(a_state), 0);
    lit("arst_stall", int'(a_stall), 0);
    lit("arst_fev", int'(b_fev), 0);
    tick(); rst_n = 1; evalchk();
    lit("post_rst_pc_en", int'(a_pc_en), 1);
    lit("post_rst_exmem_en", int'(a_exmem_en), 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n        = ($urandom_range(0, 199) != 0);
      id_valid     = 1'($urandom_range(0, 1));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rs1       = 5'($urandom_range(0, 3));
      ex_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_load      = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite  = 1'($urandom_range(0, 1));
      ex_redirect  = ($urandom_range(0, 5) == 0);
      dmem_busy    = ($urandom_range(0, 4) == 0);
      evalchk();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
